// File: rtl/ui_menu_controller.sv
// Front-panel button controller: synchronise, debounce and edge-detect three
// raw buttons, auto-repeat Next/Prev, and maintain the UI menu selection.
module ui_menu_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock25MHz,
    input  logic       resetN,
    input  logic       btnMode,
    input  logic       btnNext,
    input  logic       btnPrev,
    output logic       uiMode,
    output logic [1:0] selectedChannel,
    output logic       selectedCursorPair,
    output logic       changed
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam logic [DB_W-1:0] DB_LIMIT  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_PERIOD = RP_W'(REPEAT_PERIOD);
    localparam int BTN_MODE = 0;
    localparam int BTN_NEXT = 1;
    localparam int BTN_PREV = 2;

    logic [2:0]      raw_s;
    logic [2:0]      sync1_q, sync1_d;
    logic [2:0]      sync2_q, sync2_d;
    logic [2:0]      stable_q, stable_d;
    logic [2:0]      stable_prev_q, stable_prev_d;
    logic [2:0]      press_s;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    // Index 0 tracks Next, index 1 tracks Prev.
    logic [RP_W-1:0] hold_cnt_q [2];
    logic [RP_W-1:0] hold_cnt_d [2];
    logic [1:0]      repeating_q, repeating_d;
    logic [1:0]      repeat_s;
    logic            both_held_s;

    logic            mode_ev_s, next_ev_s, prev_ev_s;
    logic            ui_mode_q, ui_mode_d;
    logic [1:0]      channel_q, channel_d;
    logic            pair_q, pair_d;
    logic [3:0]      sel_prev_q, sel_prev_d;
    logic            changed_q, changed_d;

    assign raw_s = {btnPrev, btnNext, btnMode};

    // Synchroniser shift, debounce counters and press edge detection.
    always_comb begin
        sync1_d       = raw_s;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = {DB_W{1'b0}};
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end else if (db_cnt_q[i] == DB_LIMIT) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = {DB_W{1'b0}};
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        press_s = stable_q & ~stable_prev_q;
    end

    assign both_held_s = stable_q[BTN_NEXT] & stable_q[BTN_PREV];

    // Hold counters: count from the press, first repeat after REPEAT_DELAY,
    // then every REPEAT_PERIOD; a count of zero means idle.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            hold_cnt_d[j]  = hold_cnt_q[j];
            repeating_d[j] = repeating_q[j];
            repeat_s[j]    = stable_q[j + 1] & ~both_held_s &
                             (hold_cnt_q[j] != {RP_W{1'b0}}) &
                             (repeating_q[j] ? (hold_cnt_q[j] == RP_PERIOD)
                                             : (hold_cnt_q[j] == RP_DELAY));
            if (!stable_q[j + 1] || both_held_s) begin
                hold_cnt_d[j]  = {RP_W{1'b0}};
                repeating_d[j] = 1'b0;
            end else if (press_s[j + 1]) begin
                hold_cnt_d[j]  = RP_W'(1);
                repeating_d[j] = 1'b0;
            end else if (repeat_s[j]) begin
                hold_cnt_d[j]  = RP_W'(1);
                repeating_d[j] = 1'b1;
            end else if (hold_cnt_q[j] != {RP_W{1'b0}}) begin
                hold_cnt_d[j]  = hold_cnt_q[j] + RP_W'(1);
            end else begin
                hold_cnt_d[j]  = {RP_W{1'b0}};
            end
        end
    end

    // Event resolution: Mode wins, simultaneous Next/Prev cancel.
    always_comb begin
        mode_ev_s = press_s[BTN_MODE];
        next_ev_s = press_s[BTN_NEXT] | repeat_s[0];
        prev_ev_s = press_s[BTN_PREV] | repeat_s[1];
        ui_mode_d = ui_mode_q;
        channel_d = channel_q;
        pair_d    = pair_q;
        if (mode_ev_s) begin
            ui_mode_d = ~ui_mode_q;
        end else if (next_ev_s ^ prev_ev_s) begin
            if (ui_mode_q) begin
                pair_d = ~pair_q;
            end else if (next_ev_s) begin
                channel_d = channel_q + 2'd1;
            end else begin
                channel_d = channel_q - 2'd1;
            end
        end else begin
            ui_mode_d = ui_mode_q;
        end
        sel_prev_d = {ui_mode_q, channel_q, pair_q};
        changed_d  = (sel_prev_d != sel_prev_q);
    end

    // State registers.
    always_ff @(posedge clock25MHz or negedge resetN) begin
        if (!resetN) begin
            sync1_q       <= 3'b000;
            sync2_q       <= 3'b000;
            stable_q      <= 3'b000;
            stable_prev_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= {DB_W{1'b0}};
            end
            for (int j = 0; j < 2; j++) begin
                hold_cnt_q[j] <= {RP_W{1'b0}};
            end
            repeating_q   <= 2'b00;
            ui_mode_q     <= 1'b0;
            channel_q     <= 2'd0;
            pair_q        <= 1'b0;
            sel_prev_q    <= 4'd0;
            changed_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int j = 0; j < 2; j++) begin
                hold_cnt_q[j] <= hold_cnt_d[j];
            end
            repeating_q   <= repeating_d;
            ui_mode_q     <= ui_mode_d;
            channel_q     <= channel_d;
            pair_q        <= pair_d;
            sel_prev_q    <= sel_prev_d;
            changed_q     <= changed_d;
        end
    end

    assign uiMode             = ui_mode_q;
    assign selectedChannel    = channel_q;
    assign selectedCursorPair = pair_q;
    assign changed            = changed_q;

endmodule

// File: tb/tb_ui_menu_controller.sv
// Bench for ui_menu_controller: directed scenarios with spec-derived timing
// plus randomized button traffic checked against a run-length event model.
module tb_ui_menu_controller;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int N  = 1500;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       b_mode, b_next, b_prev;
    logic       ui_mode;
    logic [1:0] sel_ch;
    logic       sel_pair;
    logic       changed;

    int total = 0;
    int bad   = 0;

    logic [2:0] raw_a [N];
    logic [2:0] ev_a  [N];
    logic [3:0] exp_a [N];

    always #5 clk = ~clk;

    ui_menu_controller #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock25MHz        (clk),
        .resetN            (rst_n),
        .btnMode           (b_mode),
        .btnNext           (b_next),
        .btnPrev           (b_prev),
        .uiMode            (ui_mode),
        .selectedChannel   (sel_ch),
        .selectedCursorPair(sel_pair),
        .changed           (changed)
    );

    function automatic logic [4:0] observed();
        return {ui_mode, sel_ch, sel_pair, changed};
    endfunction

    // Drive raw levels before edge k, then sample 1 time unit after edge k.
    task automatic step(input logic m, input logic n, input logic p);
        @(negedge clk);
        b_mode = m;
        b_next = n;
        b_prev = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b_mode = 1'b0; b_next = 1'b0; b_prev = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (observed() !== 5'b00000) begin
            bad++;
            $display("FAIL reset_held got=%b want=%b", observed(), 5'b00000);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (observed() !== 5'b00000) begin
                bad++;
                $display("FAIL reset_idle k=%0d got=%b want=%b", k, observed(), 5'b00000);
            end
        end
    endtask

    task automatic test_single_press();
        logic [4:0] want;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, (k < 10), 1'b0);
            want = {1'b0, (k >= 7) ? 2'd1 : 2'd0, 1'b0, (k == 8)};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL single_next k=%0d got=%b want=%b", k, observed(), want);
            end
        end
    endtask

    task automatic test_prev_and_glitch();
        logic [1:0] before_ch [3] = '{2'd1, 2'd0, 2'd3};
        logic [1:0] after_ch  [3] = '{2'd0, 2'd3, 2'd3};
        logic [4:0] want;
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 20; k++) begin
                if (ph < 2) step(1'b0, 1'b0, (k < 6));
                else        step(1'b0, (k < 3), 1'b0);
                want = {1'b0, (k >= 7) ? after_ch[ph] : before_ch[ph], 1'b0,
                        (k == 8) && (ph < 2)};
                total++;
                if (observed() !== want) begin
                    bad++;
                    $display("FAIL prev_glitch ph=%0d k=%0d got=%b want=%b", ph, k, observed(), want);
                end
            end
        end
    endtask

    task automatic test_hold_repeat();
        int         steps [6] = '{7, 27, 35, 43, 51, 59};
        int         cnt;
        logic       chg;
        logic [4:0] want;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k < 6), 1'b0);
            want = {1'b0, (k >= 7) ? 2'd0 : 2'd3, 1'b0, (k == 8)};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL hold_pretap k=%0d got=%b want=%b", k, observed(), want);
            end
        end
        for (int k = 0; k < 90; k++) begin
            step(1'b0, (k < 60), 1'b0);
            cnt = 0;
            chg = 1'b0;
            for (int s = 0; s < 6; s++) begin
                if (steps[s] <= k) cnt++;
                if (steps[s] == k - 1) chg = 1'b1;
            end
            want = {1'b0, 2'(cnt % 4), 1'b0, chg};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL hold_repeat k=%0d got=%b want=%b", k, observed(), want);
            end
        end
    endtask

    task automatic test_mode_cursor();
        logic [3:0] before_s [3] = '{4'b0100, 4'b1100, 4'b1101};
        logic [3:0] after_s  [3] = '{4'b1100, 4'b1101, 4'b1100};
        logic [4:0] want;
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 20; k++) begin
                step((k < 6) && (ph == 0), (k < 6) && (ph == 1), (k < 6) && (ph == 2));
                want = {(k >= 7) ? after_s[ph] : before_s[ph], (k == 8)};
                total++;
                if (observed() !== want) begin
                    bad++;
                    $display("FAIL mode_cursor ph=%0d k=%0d got=%b want=%b", ph, k, observed(), want);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] want;
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 50; k++) begin
                case (ph)
                    0:       step((k < 6), (k < 6), 1'b0);
                    1:       step(1'b0, (k < 6), (k < 6));
                    default: step(1'b0, (k < 40), (k < 40));
                endcase
                if (ph == 0) want = {(k >= 7) ? 4'b0100 : 4'b1100, (k == 8)};
                else         want = 5'b01000;
                total++;
                if (observed() !== want) begin
                    bad++;
                    $display("FAIL simultaneous ph=%0d k=%0d got=%b want=%b", ph, k, observed(), want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [4:0] want;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b1, 1'b0);
            want = {1'b0, (k >= 27) ? 2'd0 : ((k >= 7) ? 2'd3 : 2'd2), 1'b0,
                    (k == 8) || (k == 28)};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL pre_reset_hold k=%0d got=%b want=%b", k, observed(), want);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (observed() !== 5'b00000) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", observed(), 5'b00000);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, (k < 12), 1'b0);
            want = {1'b0, (k >= D + 3) ? 2'd1 : 2'd0, 1'b0, (k == D + 4)};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL held_through_reset k=%0d got=%b want=%b", k, observed(), want);
            end
        end
    endtask

    // Random single-button traffic; expected events come from raw run lengths.
    task automatic test_random();
        int         pos, len, b, rise, fall, u, k2, ch;
        logic       st, v, mm, pp;
        logic [3:0] start_s, p1, p2;
        logic [4:0] want;
        for (int k = 0; k < N; k++) begin
            raw_a[k] = 3'b000;
            ev_a[k]  = 3'b000;
        end
        pos = 0;
        while (pos < N - 150) begin
            b = $urandom_range(2, 0);
            if ($urandom_range(3, 0) == 0) len = $urandom_range(D, 1);
            else                           len = $urandom_range(60, D + 1);
            for (int i = 0; i < len; i++) raw_a[pos + i][b] = 1'b1;
            pos += len + D + 3 + $urandom_range(10, 0);
        end
        for (int bb = 0; bb < 3; bb++) begin
            st = 1'b0;
            rise = 0;
            k2 = 0;
            while (k2 < N) begin
                v = raw_a[k2][bb];
                len = 0;
                while ((k2 + len < N) && (raw_a[k2 + len][bb] == v)) len++;
                if ((v != st) && (len >= D + 1)) begin
                    st = v;
                    if (v) begin
                        rise = k2 + D + 2;
                        if (rise + 1 < N) ev_a[rise + 1][bb] = 1'b1;
                    end else if (bb != 0) begin
                        fall = k2 + D + 2;
                        u = rise + 1 + RD;
                        while ((u <= fall) && (u < N)) begin
                            ev_a[u][bb] = 1'b1;
                            u += RP;
                        end
                    end
                end
                k2 += len;
            end
        end
        mm = 1'b0; ch = 1; pp = 1'b0;
        start_s = {mm, 2'(ch), pp};
        for (int k = 0; k < N; k++) begin
            if (ev_a[k][0])                    mm = ~mm;
            else if (ev_a[k][1] && ev_a[k][2]) mm = mm;
            else if (ev_a[k][1])               begin if (mm) pp = ~pp; else ch = (ch + 1) % 4; end
            else if (ev_a[k][2])               begin if (mm) pp = ~pp; else ch = (ch + 3) % 4; end
            exp_a[k] = {mm, 2'(ch), pp};
        end
        for (int k = 0; k < N; k++) begin
            step(raw_a[k][0], raw_a[k][1], raw_a[k][2]);
            p1 = (k >= 1) ? exp_a[k - 1] : start_s;
            p2 = (k >= 2) ? exp_a[k - 2] : start_s;
            want = {exp_a[k], (p1 != p2)};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL random k=%0d raw=%b got=%b want=%b", k, raw_a[k], observed(), want);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        b_mode = 1'b0;
        b_next = 1'b0;
        b_prev = 1'b0;
        test_reset();
        test_single_press();
        test_prev_and_glitch();
        test_hold_repeat();
        test_mode_cursor();
        test_simultaneous();
        test_reset_mid_repeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ui_menu_controller.md
# ui_menu_controller

Front-panel input controller for the scope UI. It converts three raw push-buttons into the menu selection state consumed by the on-screen overlay and waveform logic: `uiMode`, `selectedChannel` and `selectedCursorPair`. It synchronises, debounces and edge-detects each button, and auto-repeats held Next/Prev. It sits between the board button pins and the overlay/renderer, in the 25 MHz pixel-clock domain.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz); minimum 2.
- `REPEAT_DELAY`, 12500000: cycles from accepted press to first auto-repeat (500 ms).
- `REPEAT_PERIOD`, 5000000: cycles between subsequent auto-repeats (200 ms).
- `clock25MHz`  in  1  sole clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `btnMode`  in  1  raw button, active-high, asynchronous to clock.
- `btnNext`  in  1  raw button, active-high, asynchronous.
- `btnPrev`  in  1  raw button, active-high, asynchronous.
- `uiMode`  out  1  0 = channel mode, 1 = cursor mode.
- `selectedChannel`  out  2  selected channel, 0..3.
- `selectedCursorPair`  out  1  0 = X1/Y1, 1 = X2/Y2.
- `changed`  out  1  one-cycle strobe, high in the cycle after any of the three selection outputs changes value.

## Operation
- Per button: 2-flop synchroniser → debouncer → rising-edge detector producing a one-cycle `press` pulse.
- Debouncer: registered `stable` level plus counter.
  - Counter clears whenever `sync == stable`.
  - Otherwise it increments.
  - When it has counted DEBOUNCE_CYCLES consecutive mismatching cycles, `stable <= sync` and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Auto-repeat (Next and Prev only, each independent):
  - A hold counter starts at that button's press pulse.
  - It emits a `repeat` pulse REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles while `stable` stays high.
  - The counter clears when `stable` falls.
  - Mode never repeats.
- Event = press or repeat pulse. Event resolution per cycle, in priority order:
  - Mode event: toggle `uiMode`. Next/Prev events in the same cycle are discarded. Channel and pair selections are preserved across mode changes.
  - Next and Prev events in the same cycle: cancel each other, no change.
  - Channel mode (`uiMode` = 0): Next → `selectedChannel + 1` mod 4 (3→0). Prev → `selectedChannel - 1` mod 4 (0→3).
  - Cursor mode (`uiMode` = 1): Next or Prev → toggle `selectedCursorPair`.
- While both Next and Prev `stable` are high, both hold counters are held cleared, so no repeats occur.
- Reset values (asynchronous on `resetN` low, any time including mid-debounce or mid-repeat):
  - `uiMode` = 0, `selectedChannel` = 0, `selectedCursorPair` = 0, `changed` = 0.
  - All synchroniser flops, `stable` levels and counters = 0.
- A button still held when `resetN` releases is re-debounced and produces one press.

## Timing
- Clean raw transition sampled at clock edge 0 → `stable` rises at edge DEBOUNCE_CYCLES+2 → selection output updates at edge DEBOUNCE_CYCLES+3 → `changed` high for exactly one cycle, from edge DEBOUNCE_CYCLES+4.
- Release: same DEBOUNCE_CYCLES+2 latency to `stable` low; release never produces an event.
- First repeat updates outputs REPEAT_DELAY cycles after the press update. Later repeats follow every REPEAT_PERIOD cycles.
- Counters are wide enough for the largest parameter and never wrap while a button is held.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset with `resetN`=0, then release, no buttons pressed → all outputs 0 indefinitely; `changed` never pulses.
- `btnNext` raised at edge 0 and held 10 cycles, then released → `selectedChannel` goes 0→1 at edge 7; `changed` is one-cycle high; no further change.
- `btnPrev` tapped from `selectedChannel`=0 → `selectedChannel`=3. A 3-cycle `btnNext` glitch → no change.
- `btnNext` held 60 cycles in channel mode → `selectedChannel` steps 1 at edge 7, 2 at edge 27, 3 at edge 35, 0 at edge 43, 1 at edge 51, 2 at edge 59. Release → stepping stops.
- `btnMode` tap → `uiMode`=1 with `selectedChannel` unchanged. Then `btnNext` tap → `selectedCursorPair`=1. Then `btnPrev` tap → `selectedCursorPair`=0.
- `btnMode` and `btnNext` presses accepted in the same cycle → only `uiMode` toggles. `btnNext` and `btnPrev` in the same cycle → no change. `resetN` pulsed low mid-repeat → all outputs 0 immediately; a held button gives exactly one press DEBOUNCE_CYCLES+3 edges after release of `resetN`.
